// File: rtl/csr_reg_bank_if.sv
// Register-bus interface for csr_reg_bank: word address, byte enables,
// write strobe and a combinational read-data return.
interface csr_reg_bank_if #(
    parameter int ADDR_W = 14,
    parameter int BE_W   = 2,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output addr, be, wr_data, wr_en,
        input  rd_data
    );

    modport slave (
        input  addr, be, wr_data, wr_en,
        output rd_data
    );
endinterface

// File: rtl/csr_reg_bank.sv
// CSR bank: version/scratch, sticky event status with masked irq, 32-bit
// saturating event counter with atomic snapshot, CTRL outputs and sampled STAT inputs.
module csr_reg_bank #(
    parameter int          REGS_DATA_W = 16,
    parameter int          REGS_ADDR_W = 14,
    parameter int          REGS_BE_W   = REGS_DATA_W >> 3,
    parameter int          CTRL_CNT    = 8,
    parameter int          STAT_CNT    = 8,
    parameter logic [15:0] VERSION     = 16'h0100
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    csr_reg_bank_if.slave         csr_if,
    output logic [CTRL_CNT*16-1:0] ctrl_o,
    input  logic [STAT_CNT*16-1:0] stat_i,
    input  logic [15:0]           evt_i,
    input  logic                  cnt_en_i,
    output logic                  irq_o
);

    typedef logic [15:0]            word_t;
    typedef logic [REGS_ADDR_W-1:0] addr_t;

    localparam addr_t A_VERSION    = addr_t'(16'h0000);
    localparam addr_t A_SCRATCH    = addr_t'(16'h0001);
    localparam addr_t A_EVT_STATUS = addr_t'(16'h0002);
    localparam addr_t A_EVT_MASK   = addr_t'(16'h0003);
    localparam addr_t A_CNT_CTRL   = addr_t'(16'h0004);
    localparam addr_t A_SNAP_LO    = addr_t'(16'h0005);
    localparam addr_t A_SNAP_HI    = addr_t'(16'h0006);
    localparam addr_t A_CTRL_BASE  = addr_t'(16'h0010);
    localparam addr_t A_STAT_BASE  = addr_t'(16'h0020);

    word_t       scratch_q,    scratch_d;
    word_t       evt_status_q, evt_status_d;
    word_t       evt_mask_q,   evt_mask_d;
    logic [31:0] cnt_q,        cnt_d;
    logic [31:0] snap_q,       snap_d;
    logic        irq_q,        irq_d;
    word_t       ctrl_q [CTRL_CNT];
    word_t       ctrl_d [CTRL_CNT];
    word_t       stat_q [STAT_CNT];
    word_t       stat_d [STAT_CNT];

    word_t               wmask;
    logic                wr_scratch, wr_evt_status, wr_evt_mask, wr_cnt_ctrl;
    logic [CTRL_CNT-1:0] wr_ctrl;
    logic                snap_req, clr_req;
    word_t               rd_data;

    // Byte-lane mask: be[0] covers bits [7:0], be[1] covers bits [15:8].
    function automatic word_t merge_be(input word_t old_v, input word_t new_v, input word_t m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin : decode
        wmask         = {{8{csr_if.be[1]}}, {8{csr_if.be[0]}}};
        wr_scratch    = csr_if.wr_en && (csr_if.addr == A_SCRATCH);
        wr_evt_status = csr_if.wr_en && (csr_if.addr == A_EVT_STATUS);
        wr_evt_mask   = csr_if.wr_en && (csr_if.addr == A_EVT_MASK);
        wr_cnt_ctrl   = csr_if.wr_en && (csr_if.addr == A_CNT_CTRL);
        for (int i = 0; i < CTRL_CNT; i++) begin
            wr_ctrl[i] = csr_if.wr_en && (csr_if.addr == A_CTRL_BASE + addr_t'(i));
        end
        snap_req = wr_cnt_ctrl && csr_if.be[0] && csr_if.wr_data[0];
        clr_req  = wr_cnt_ctrl && csr_if.be[0] && csr_if.wr_data[1];
    end

    always_comb begin : next_state
        scratch_d  = scratch_q;
        evt_mask_d = evt_mask_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;

        if (wr_scratch)  scratch_d  = merge_be(scratch_q,  csr_if.wr_data, wmask);
        if (wr_evt_mask) evt_mask_d = merge_be(evt_mask_q, csr_if.wr_data, wmask);

        // Clear first, then OR in new events so a same-cycle event wins.
        evt_status_d = evt_status_q;
        if (wr_evt_status) evt_status_d = evt_status_q & ~(csr_if.wr_data & wmask);
        evt_status_d = evt_status_d | evt_i;

        irq_d = |(evt_status_q & evt_mask_q);

        // Snapshot sees the pre-edge count, so it captures the value before any clear.
        if (snap_req) snap_d = cnt_q;
        if (clr_req) begin
            cnt_d = '0;
        end else if (cnt_en_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end

        for (int i = 0; i < CTRL_CNT; i++) begin
            ctrl_d[i] = wr_ctrl[i] ? merge_be(ctrl_q[i], csr_if.wr_data, wmask) : ctrl_q[i];
        end
        for (int i = 0; i < STAT_CNT; i++) begin
            stat_d[i] = stat_i[16*i +: 16];
        end
    end

    always_comb begin : read_mux
        rd_data = '0;
        case (csr_if.addr)
            A_VERSION:    rd_data = VERSION;
            A_SCRATCH:    rd_data = scratch_q;
            A_EVT_STATUS: rd_data = evt_status_q;
            A_EVT_MASK:   rd_data = evt_mask_q;
            A_SNAP_LO:    rd_data = snap_q[15:0];
            A_SNAP_HI:    rd_data = snap_q[31:16];
            default:      rd_data = '0;
        endcase
        for (int i = 0; i < CTRL_CNT; i++) begin
            if (csr_if.addr == A_CTRL_BASE + addr_t'(i)) rd_data = ctrl_q[i];
        end
        for (int i = 0; i < STAT_CNT; i++) begin
            if (csr_if.addr == A_STAT_BASE + addr_t'(i)) rd_data = stat_q[i];
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scratch_q    <= '0;
            evt_status_q <= '0;
            evt_mask_q   <= '0;
            cnt_q        <= '0;
            snap_q       <= '0;
            irq_q        <= 1'b0;
            // NOTE: the CTRL/STAT arrays are plain flops, not RAM, so they reset with everything else.
            for (int i = 0; i < CTRL_CNT; i++) ctrl_q[i] <= '0;
            for (int i = 0; i < STAT_CNT; i++) stat_q[i] <= '0;
        end else begin
            scratch_q    <= scratch_d;
            evt_status_q <= evt_status_d;
            evt_mask_q   <= evt_mask_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            irq_q        <= irq_d;
            for (int i = 0; i < CTRL_CNT; i++) ctrl_q[i] <= ctrl_d[i];
            for (int i = 0; i < STAT_CNT; i++) stat_q[i] <= stat_d[i];
        end
    end

    for (genvar g = 0; g < CTRL_CNT; g++) begin : g_ctrl_out
        assign ctrl_o[16*g +: 16] = ctrl_q[g];
    end

    assign csr_if.rd_data = rd_data;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_csr_reg_bank.sv
// Self-checking bench for csr_reg_bank: expected reads are queued when
// stimulus is applied and compared when the read address is presented.
module tb_csr_reg_bank;

    localparam int CTRL_CNT = 8;
    localparam int STAT_CNT = 8;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [CTRL_CNT*16-1:0] ctrl_o;
    logic [STAT_CNT*16-1:0] stat_i;
    logic [15:0]            evt_i;
    logic                   cnt_en_i;
    logic                   irq_o;

    csr_reg_bank_if #(.ADDR_W(14), .BE_W(2), .DATA_W(16)) csr ();

    csr_reg_bank #(
        .REGS_DATA_W(16), .REGS_ADDR_W(14), .REGS_BE_W(2),
        .CTRL_CNT(CTRL_CNT), .STAT_CNT(STAT_CNT), .VERSION(16'h0100)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .csr_if   (csr),
        .ctrl_o   (ctrl_o),
        .stat_i   (stat_i),
        .evt_i    (evt_i),
        .cnt_en_i (cnt_en_i),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [13:0] addr;
        logic [15:0] exp;
    } rd_t;

    rd_t sb[$];
    rd_t e_cur;

    task automatic expect_rd(input string name, input logic [13:0] addr, input logic [15:0] exp);
        rd_t e;
        e.name = name;
        e.addr = addr;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic do_write(input logic [13:0] addr, input logic [15:0] data, input logic [1:0] be);
        @(negedge clk_i);
        csr.addr    = addr;
        csr.wr_data = data;
        csr.be      = be;
        csr.wr_en   = 1'b1;
        @(negedge clk_i);
        csr.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        stat_i      = {STAT_CNT{16'hFACE}};
        evt_i       = 16'hFFFF;
        cnt_en_i    = 1'b1;
        csr.addr    = 14'h0001;
        csr.wr_data = 16'hFFFF;
        csr.be      = 2'b11;
        csr.wr_en   = 1'b1;
        repeat (3) @(negedge clk_i);
        total++;
        if (ctrl_o !== '0) begin bad++; $display("FAIL reset_ctrl_o: got=%h want=0", ctrl_o); end
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq: got=%b want=0", irq_o); end
        expect_rd("stat0_in_reset", 14'h0020, 16'h0000);
        expect_rd("scratch_in_reset", 14'h0001, 16'h0000);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
        @(negedge clk_i);
        rst_i     = 1'b0;
        evt_i     = '0;
        cnt_en_i  = 1'b0;
        csr.wr_en = 1'b0;
        stat_i    = '0;
        expect_rd("version",    14'h0000, 16'h0100);
        expect_rd("scratch",    14'h0001, 16'h0000);
        expect_rd("ctrl0",      14'h0010, 16'h0000);
        expect_rd("evt_status", 14'h0002, 16'h0000);
        expect_rd("evt_mask",   14'h0003, 16'h0000);
        expect_rd("snap_lo",    14'h0005, 16'h0000);
        expect_rd("snap_hi",    14'h0006, 16'h0000);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
    endtask

    task automatic test_ctrl_be();
        do_write(14'h0010, 16'hCD00, 2'b11);
        do_write(14'h0010, 16'hABCD, 2'b01);
        total++;
        if (ctrl_o[15:0] !== 16'hCDCD) begin bad++; $display("FAIL ctrl0_be01: got=%h want=cdcd", ctrl_o[15:0]); end
        @(negedge clk_i);
        csr.addr = 14'h0010; csr.wr_data = 16'h1234; csr.be = 2'b10; csr.wr_en = 1'b1;
        #1;
        total++;
        if (ctrl_o[15:0] !== 16'hCDCD) begin bad++; $display("FAIL ctrl0_before_edge: got=%h want=cdcd", ctrl_o[15:0]); end
        @(negedge clk_i);
        csr.wr_en = 1'b0;
        total++;
        if (ctrl_o[15:0] !== 16'h12CD) begin bad++; $display("FAIL ctrl0_be10: got=%h want=12cd", ctrl_o[15:0]); end
        do_write(14'h0017, 16'h7777, 2'b11);
        do_write(14'h0018, 16'h8888, 2'b11);
        do_write(14'h1001, 16'hBEEF, 2'b11);
        total++;
        if (ctrl_o !== {16'h7777, 96'h0, 16'h12CD}) begin bad++; $display("FAIL ctrl_o_vector: got=%h", ctrl_o); end
        expect_rd("ctrl0_rd",       14'h0010, 16'h12CD);
        expect_rd("ctrl7_rd",       14'h0017, 16'h7777);
        expect_rd("ctrl_past_end",  14'h0018, 16'h0000);
        expect_rd("ctrl0_alias",    14'h2010, 16'h0000);
        expect_rd("scratch_alias",  14'h0001, 16'h0000);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
    endtask

    task automatic test_stat();
        @(negedge clk_i);
        stat_i[15:0]    = 16'hA5A5;
        stat_i[127:112] = 16'h5A5A;
        csr.addr = 14'h0020;
        #1;
        total++;
        if (csr.rd_data !== 16'h0000) begin bad++; $display("FAIL stat0_latency: got=%h want=0000", csr.rd_data); end
        do_write(14'h0020, 16'hFFFF, 2'b11);
        expect_rd("stat0",         14'h0020, 16'hA5A5);
        expect_rd("stat7",         14'h0027, 16'h5A5A);
        expect_rd("stat_past_end", 14'h0028, 16'h0000);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
    endtask

    task automatic test_evt_irq();
        do_write(14'h0003, 16'h0001, 2'b11);
        @(negedge clk_i); evt_i = 16'h0001;
        @(negedge clk_i); evt_i = 16'h0000;
        csr.addr = 14'h0002; #1;
        total++;
        if (csr.rd_data !== 16'h0001) begin bad++; $display("FAIL evt_set: got=%h want=0001", csr.rd_data); end
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_latency: got=%b want=0", irq_o); end
        @(negedge clk_i);
        total++;
        if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_rise: got=%b want=1", irq_o); end
        @(negedge clk_i);
        csr.addr = 14'h0002; csr.wr_data = 16'h0001; csr.be = 2'b11; csr.wr_en = 1'b1; evt_i = 16'h0001;
        @(negedge clk_i);
        csr.wr_en = 1'b0; evt_i = 16'h0000; #1;
        total++;
        if (csr.rd_data !== 16'h0001) begin bad++; $display("FAIL evt_set_wins: got=%h want=0001", csr.rd_data); end
        do_write(14'h0002, 16'h0001, 2'b11);
        #1;
        total++;
        if (csr.rd_data !== 16'h0000) begin bad++; $display("FAIL evt_w1c: got=%h want=0000", csr.rd_data); end
        total++;
        if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_fall_latency: got=%b want=1", irq_o); end
        @(negedge clk_i);
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_fall: got=%b want=0", irq_o); end
        @(negedge clk_i); evt_i = 16'h0108;
        @(negedge clk_i); evt_i = 16'h0000;
        @(negedge clk_i);
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_masked: got=%b want=0", irq_o); end
        expect_rd("evt_unmasked", 14'h0002, 16'h0108);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
        do_write(14'h0002, 16'h0108, 2'b01);
        expect_rd("evt_w1c_lo_only", 14'h0002, 16'h0100);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
        do_write(14'h0002, 16'h0108, 2'b10);
        expect_rd("evt_w1c_hi_only", 14'h0002, 16'h0000);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
    endtask

    task automatic test_counter();
        do_write(14'h0004, 16'h0002, 2'b01);
        @(negedge clk_i); cnt_en_i = 1'b1;
        repeat (100) @(negedge clk_i);
        cnt_en_i = 1'b0;
        do_write(14'h0004, 16'h0003, 2'b01);
        expect_rd("snap_lo_100", 14'h0005, 16'd100);
        expect_rd("snap_hi_100", 14'h0006, 16'h0000);
        expect_rd("cnt_ctrl_wo", 14'h0004, 16'h0000);
        do_write(14'h0004, 16'h0000, 2'b11);
        do_write(14'h0004, 16'h0001, 2'b10);
        do_write(14'h0005, 16'hFFFF, 2'b11);
        expect_rd("snap_lo_held", 14'h0005, 16'd100);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
        do_write(14'h0004, 16'h0001, 2'b01);
        expect_rd("snap_lo_after_clr", 14'h0005, 16'h0000);
        expect_rd("snap_hi_after_clr", 14'h0006, 16'h0000);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
        @(negedge clk_i); cnt_en_i = 1'b1;
        repeat (5) @(negedge clk_i);
        do_write(14'h0004, 16'h0002, 2'b01);
        cnt_en_i = 1'b0;
        do_write(14'h0004, 16'h0001, 2'b01);
        expect_rd("clr_beats_inc", 14'h0005, 16'h0000);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
    endtask

    task automatic test_saturate();
        @(negedge clk_i);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        do_write(14'h0004, 16'h0001, 2'b01);
        expect_rd("preset_lo", 14'h0005, 16'hFFFE);
        expect_rd("preset_hi", 14'h0006, 16'hFFFF);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
        @(negedge clk_i); cnt_en_i = 1'b1;
        repeat (3) @(negedge clk_i);
        cnt_en_i = 1'b0;
        do_write(14'h0004, 16'h0001, 2'b01);
        expect_rd("sat_lo", 14'h0005, 16'hFFFF);
        expect_rd("sat_hi", 14'h0006, 16'hFFFF);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        csr.addr = 14'h0001; csr.wr_data = 16'h1111; csr.be = 2'b11; csr.wr_en = 1'b1;
        @(negedge clk_i);
        csr.addr = 14'h0011; csr.wr_data = 16'h2222; csr.be = 2'b11;
        @(negedge clk_i);
        csr.addr = 14'h0001; csr.wr_data = 16'h3333; csr.be = 2'b01;
        @(negedge clk_i);
        csr.wr_en = 1'b0;
        total++;
        if (ctrl_o[31:16] !== 16'h2222) begin bad++; $display("FAIL b2b_ctrl1_out: got=%h want=2222", ctrl_o[31:16]); end
        expect_rd("b2b_scratch", 14'h0001, 16'h1133);
        expect_rd("b2b_ctrl1",   14'h0011, 16'h2222);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
    endtask

    task automatic test_reset_priority();
        do_write(14'h0003, 16'h0001, 2'b11);
        @(negedge clk_i); evt_i = 16'h0001;
        @(negedge clk_i); evt_i = 16'h0000;
        @(negedge clk_i);
        total++;
        if (irq_o !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got=%b want=1", irq_o); end
        @(negedge clk_i);
        rst_i = 1'b1; evt_i = 16'hFFFF; cnt_en_i = 1'b1;
        csr.addr = 14'h0001; csr.wr_data = 16'h5555; csr.be = 2'b11; csr.wr_en = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; evt_i = 16'h0000; cnt_en_i = 1'b0; csr.wr_en = 1'b0;
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL mid_reset_irq: got=%b want=0", irq_o); end
        total++;
        if (ctrl_o !== '0) begin bad++; $display("FAIL mid_reset_ctrl_o: got=%h want=0", ctrl_o); end
        expect_rd("rst_scratch",  14'h0001, 16'h0000);
        expect_rd("rst_evt",      14'h0002, 16'h0000);
        expect_rd("rst_mask",     14'h0003, 16'h0000);
        expect_rd("rst_snap_lo",  14'h0005, 16'h0000);
        expect_rd("rst_snap_hi",  14'h0006, 16'h0000);
        expect_rd("unmapped_07",  14'h0007, 16'h0000);
        expect_rd("unmapped_top", 14'h3FFF, 16'h0000);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
        do_write(14'h0004, 16'h0001, 2'b01);
        do_write(14'h0000, 16'hFFFF, 2'b11);
        do_write(14'h3FFF, 16'hFFFF, 2'b11);
        expect_rd("rst_cnt_snap",   14'h0005, 16'h0000);
        expect_rd("version_ro",     14'h0000, 16'h0100);
        expect_rd("unmapped_wr_rd", 14'h3FFF, 16'h0000);
        while (sb.size() > 0) begin
            e_cur = sb.pop_front();
            @(negedge clk_i); csr.addr = e_cur.addr; #1;
            total++;
            if (csr.rd_data !== e_cur.exp) begin bad++; $display("FAIL %s: got=%h want=%h", e_cur.name, csr.rd_data, e_cur.exp); end
        end
    endtask

    initial begin
        csr.addr    = '0;
        csr.be      = '0;
        csr.wr_data = '0;
        csr.wr_en   = 1'b0;
        stat_i      = '0;
        evt_i       = '0;
        cnt_en_i    = 1'b0;
        rst_i       = 1'b1;
        test_reset();
        test_ctrl_be();
        test_stat();
        test_evt_irq();
        test_counter();
        test_saturate();
        test_back_to_back();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
